// File: rtl/irq_pkg.sv
// irq_pkg: shared state encoding, register offsets and bit positions for the
// interrupt priority arbiter.
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    // Byte offsets; only bits [4:2] of the address take part in decoding.
    localparam logic [4:0] OFS_CTRL   = 5'h00;
    localparam logic [4:0] OFS_MASK   = 5'h04;
    localparam logic [4:0] OFS_PEND   = 5'h08;
    localparam logic [4:0] OFS_PRIO   = 5'h0C;
    localparam logic [4:0] OFS_STATUS = 5'h10;
    localparam logic [4:0] OFS_EOI    = 5'h14;

    localparam int CTRL_EN_BIT      = 0;
    localparam int STATUS_ID_LSB    = 0;
    localparam int STATUS_STATE_LSB = 3;
    localparam int STATUS_TMO_BIT   = 5;

endpackage

// File: rtl/irq_prio_select.sv
// irq_prio_select: combinational winner among eligible sources; the highest
// priority wins and ties go to the lowest index.
module irq_prio_select #(
    parameter int NUM_SRC = 4,
    parameter int PRIO_W  = 2
) (
    input  logic [NUM_SRC-1:0]        eligible,
    input  logic [NUM_SRC*PRIO_W-1:0] prio,
    output logic [2:0]                winner,
    output logic                      valid
);

    logic [PRIO_W-1:0] prio_arr [NUM_SRC];
    logic [PRIO_W-1:0] best_prio;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign prio_arr[gi] = prio[gi*PRIO_W +: PRIO_W];
        end
    endgenerate

    // Strict greater-than keeps the earlier (lower-index) source on a tie.
    always_comb begin
        winner    = '0;
        valid     = 1'b0;
        best_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (eligible[i] && (!valid || prio_arr[i] > best_prio)) begin
                valid     = 1'b1;
                winner    = 3'(i);
                best_prio = prio_arr[i];
            end
        end
    end

endmodule

// File: rtl/irq_priority_arbiter.sv
// irq_priority_arbiter: APB-programmed priority/mask interrupt arbiter with an
// assert/ack/EOI handshake. Optional macro IRQ_ACK_TIMEOUT_EN adds an ack timeout.
module irq_priority_arbiter
    import irq_pkg::*;
#(
    parameter int NUM_SRC        = 4,
    parameter int PRIO_W         = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               pclk_i,
    input  logic               rst_n_i,
    input  logic               psel_i,
    input  logic               penable_i,
    input  logic               pwrite_i,
    input  logic [31:0]        paddr_i,
    input  logic [31:0]        pwdata_i,
    output logic [31:0]        prdata_o,
    output logic               pready_o,
    output logic               pslverr_o,
    input  logic [NUM_SRC-1:0] irq_req_i,
    output logic               irq_o,
    output logic [2:0]         irq_id_o,
    input  logic               irq_ack_i
);

`ifdef IRQ_ACK_TIMEOUT_EN
    localparam bit STATUS_WRITABLE = 1'b1;
`else
    localparam bit STATUS_WRITABLE = 1'b0;
`endif

    logic                      ctrl_en_reg;
    logic [NUM_SRC-1:0]        mask_reg;
    logic [NUM_SRC-1:0]        pend_reg, pend_next;
    logic [NUM_SRC*PRIO_W-1:0] prio_reg;
    logic [2:0]                id_reg, id_next;
    irq_state_e                state_reg, state_next;

    logic [NUM_SRC-1:0]        eligible;
    logic [2:0]                win_id;
    logic                      win_valid;
    logic [7:0]                mask_ext;
    logic                      presented_ok;
    logic                      tmo_hit;
    logic                      status_tmo;

    logic                      apb_access, apb_wr, apb_rd;
    logic                      addr_valid, wr_ro, apb_err, wr_ok, eoi;
    logic [4:0]                ofs;
    logic [31:0]               rdata;
    logic                      unused_ok;

    assign apb_access = psel_i & penable_i;
    assign apb_wr     = apb_access & pwrite_i;
    assign apb_rd     = apb_access & ~pwrite_i;
    assign ofs        = {paddr_i[4:2], 2'b00};
    assign addr_valid = (ofs <= OFS_EOI);
    assign wr_ro      = apb_wr & ((ofs == OFS_PEND) | ((ofs == OFS_STATUS) & ~STATUS_WRITABLE));
    assign apb_err    = apb_access & (~addr_valid | wr_ro);
    assign wr_ok      = apb_wr & ~apb_err;
    assign eoi        = wr_ok & (ofs == OFS_EOI) & (state_reg == ST_SERVICE);

    assign pready_o  = 1'b1;
    assign pslverr_o = apb_err;
    assign prdata_o  = apb_rd ? rdata : '0;
    assign irq_o     = (state_reg == ST_ASSERT);
    assign irq_id_o  = id_reg;

    assign unused_ok = ^{paddr_i, pwdata_i, (TIMEOUT_CYCLES != 0)};

    assign eligible     = pend_reg & mask_reg & {NUM_SRC{ctrl_en_reg}};
    assign mask_ext     = 8'(mask_reg);
    assign presented_ok = ctrl_en_reg & mask_ext[id_reg];

    irq_prio_select #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W)
    ) u_select (
        .eligible (eligible),
        .prio     (prio_reg),
        .winner   (win_id),
        .valid    (win_valid)
    );

    // A pending bit cleared by EOI is immediately re-set if its line is still high.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_pend
            assign pend_next[gi] = irq_req_i[gi] |
                                   (pend_reg[gi] & ~(eoi & (id_reg == 3'(gi))));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        id_next    = id_reg;
        case (state_reg)
            ST_IDLE: begin
                if (win_valid) begin
                    id_next    = win_id;
                    state_next = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (!presented_ok || tmo_hit) begin
                    state_next = ST_IDLE;
                end else if (irq_ack_i) begin
                    state_next = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (eoi) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_en_reg <= 1'b0;
            mask_reg    <= '0;
            pend_reg    <= '0;
            prio_reg    <= '0;
            id_reg      <= '0;
            state_reg   <= ST_IDLE;
        end else begin
            pend_reg  <= pend_next;
            id_reg    <= id_next;
            state_reg <= state_next;
            if (wr_ok && ofs == OFS_CTRL) begin
                ctrl_en_reg <= pwdata_i[CTRL_EN_BIT];
            end
            if (wr_ok && ofs == OFS_MASK) begin
                mask_reg <= pwdata_i[NUM_SRC-1:0];
            end
            if (wr_ok && ofs == OFS_PRIO) begin
                prio_reg <= pwdata_i[NUM_SRC*PRIO_W-1:0];
            end
        end
    end

`ifdef IRQ_ACK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic             tmo_flag_reg;

    // The count is the number of cycles already spent in ASSERT.
    assign tmo_hit      = (state_reg == ST_ASSERT) & ~irq_ack_i &
                          (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
    assign tmo_cnt_next = (state_reg == ST_ASSERT && state_next == ST_ASSERT) ?
                          tmo_cnt_reg + CNT_W'(1) : '0;
    assign status_tmo   = tmo_flag_reg;

    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmo_cnt_reg  <= '0;
            tmo_flag_reg <= 1'b0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_next;
            if (tmo_hit) begin
                tmo_flag_reg <= 1'b1;
            end else if (wr_ok && ofs == OFS_STATUS && pwdata_i[STATUS_TMO_BIT]) begin
                tmo_flag_reg <= 1'b0;
            end
        end
    end
`else
    assign tmo_hit    = 1'b0;
    assign status_tmo = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (ofs)
            OFS_CTRL:   rdata[CTRL_EN_BIT] = ctrl_en_reg;
            OFS_MASK:   rdata[NUM_SRC-1:0] = mask_reg;
            OFS_PEND:   rdata[NUM_SRC-1:0] = pend_reg;
            OFS_PRIO:   rdata[NUM_SRC*PRIO_W-1:0] = prio_reg;
            OFS_STATUS: begin
                rdata[STATUS_ID_LSB +: 3]    = id_reg;
                rdata[STATUS_STATE_LSB +: 2] = state_reg;
                rdata[STATUS_TMO_BIT]        = status_tmo;
            end
            default: rdata = '0;
        endcase
    end

endmodule
